// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - InstructionSetPkg: opcodes, field positions and fetch FSM states
package InstructionSetPkg;

  localparam int AddressWidth = 16;
  localparam int InstrWidth   = 16;

  localparam int OpCodeStart = 12;
  localparam int OpCodeSize  = 4;
  localparam int RegAStart   = 6;
  localparam int RegASize    = 6;
  localparam int RegBStart   = 0;
  localparam int RegBSize    = 6;

  localparam logic [RegASize-1:0] SPECIAL_PC = 6'd63;

  typedef enum logic [OpCodeSize-1:0] {
    ADD   = 4'h0,
    SUB   = 4'h1,
    LOAD  = 4'h2,
    MOVE  = 4'h3,
    STORE = 4'h4,
    AND   = 4'h5,
    OR    = 4'h6,
    XOR   = 4'h7,
    SHL   = 4'h8,
    SHR   = 4'h9,
    ADC   = 4'hA,
    SBC   = 4'hB,
    CMP   = 4'hC,
    JR    = 4'hD,
    LDI   = 4'hE,
    NOP   = 4'hF
  } eOperation;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } eFetchState;

endpackage

// File: rtl/instruction_fetch_field_decode.sv
// rtl/instruction_fetch_field_decode.sv - combinational split of an instruction word into fields
module instruction_field_decode
  import InstructionSetPkg::*;
(
  input  logic [InstrWidth-1:0] i_instr_word,
  output eOperation             o_op_code,
  output logic [RegASize-1:0]   o_reg_a,
  output logic [RegBSize-1:0]   o_reg_b,
  output logic                  o_pc_write
);

  assign o_op_code = eOperation'(i_instr_word[OpCodeStart +: OpCodeSize]);
  assign o_reg_a   = i_instr_word[RegAStart +: RegASize];
  assign o_reg_b   = i_instr_word[RegBStart +: RegBSize];

  // STORE reads the PC as a source and JR redirects through execute, so neither writes it here
  assign o_pc_write = (o_reg_a == SPECIAL_PC) && (o_op_code != STORE) && (o_op_code != JR);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding-request instruction fetch with jump redirect
// Optional FETCH_TRACE_EN adds the FetchCount accepted-instruction counter.
module instruction_fetch
  import InstructionSetPkg::*;
#(
  parameter int               Width       = AddressWidth,
  parameter logic [Width-1:0] ResetVector = Width'(16'h0000)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  output logic                  MemReq,
  output logic [Width-1:0]      MemAddr,
  input  logic                  MemAck,
  input  logic [InstrWidth-1:0] MemData,
  input  logic                  Jump,
  input  logic [Width-1:0]      JumpTarget,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  output logic [InstrWidth-1:0] InstrWord,
  output logic [Width-1:0]      InstrPc,
  output eOperation             OpCode,
  output logic [RegASize-1:0]   RegA,
  output logic [RegBSize-1:0]   RegB,
`ifdef FETCH_TRACE_EN
  output logic [31:0]           FetchCount,
`endif
  output logic                  PcWrite
);

  eFetchState            r_state;
  eFetchState            w_state_next;
  logic                  r_mem_req;
  logic [Width-1:0]      r_pc;
  logic [Width-1:0]      r_req_addr;
  logic [Width-1:0]      r_instr_pc;
  logic [InstrWidth-1:0] r_instr_word;
  logic                  r_instr_valid;

  logic                  w_ack;
  logic [Width-1:0]      w_pc_next;
  logic                  w_capture;
  logic                  w_valid_next;
  logic                  w_req_next;

  // An ack only counts against a request that is actually visible on the bus
  assign w_ack = MemAck & r_mem_req;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    w_valid_next = r_instr_valid;
    case (r_state)
      FETCH: begin
        if (Jump) begin
          w_pc_next    = JumpTarget;
          w_state_next = (r_mem_req && !w_ack) ? DRAIN : FETCH;
        end else if (w_ack) begin
          w_capture    = 1'b1;
          w_pc_next    = r_pc + 1'b1;
          w_valid_next = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (Jump) begin
          w_pc_next    = JumpTarget;
          w_valid_next = 1'b0;
          w_state_next = FETCH;
        end else if (InstrReady) begin
          w_valid_next = 1'b0;
          w_state_next = FETCH;
        end
      end
      DRAIN: begin
        if (Jump) begin
          w_pc_next = JumpTarget;
        end
        if (w_ack) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
    w_req_next = (w_state_next != HOLD);
  end

  // The bus address only moves when a fresh FETCH begins, so DRAIN keeps the abandoned address
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_pc          <= ResetVector;
      r_req_addr    <= ResetVector;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_word  <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_mem_req     <= w_req_next;
      r_instr_valid <= w_valid_next;
      if (w_state_next == FETCH) begin
        r_req_addr <= w_pc_next;
      end
      if (w_capture) begin
        r_instr_word <= MemData;
        r_instr_pc   <= r_req_addr;
      end
    end
  end

  assign MemReq     = r_mem_req;
  assign MemAddr    = r_req_addr;
  assign InstrValid = r_instr_valid;
  assign InstrWord  = r_instr_word;
  assign InstrPc    = r_instr_pc;

`ifdef FETCH_TRACE_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_fetch_count <= '0;
    end else if (r_instr_valid && InstrReady && !Jump) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign FetchCount = r_fetch_count;
`endif

  instruction_field_decode u_field_decode (
    .i_instr_word (r_instr_word),
    .o_op_code    (OpCode),
    .o_reg_a      (RegA),
    .o_reg_b      (RegB),
    .o_pc_write   (PcWrite)
  );

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ResetVector, default 16'h0000, the first PC fetched after reset.
REQ-002 SHALL have parameter Width, default AddressWidth (16), the PC/address width; the instruction word is fixed at 16 bits.
REQ-003 Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 MemReq  output  1  instruction-memory read request.
REQ-006 MemAddr  output  Width  read address, valid while MemReq=1.
REQ-007 MemAck  input  1  memory response strobe; MemData valid in the same cycle.
REQ-008 MemData  input  16  instruction word.
REQ-009 Jump  input  1  single-cycle redirect strobe from execute (JR or write to SPECIAL_PC).
REQ-010 JumpTarget  input  Width  redirect address, sampled when Jump=1.
REQ-011 InstrValid  output  1  decoded instruction available.
REQ-012 InstrReady  input  1  downstream (decode/ALU) accepts the instruction.
REQ-013 InstrWord  output  16  raw instruction.
REQ-014 InstrPc  output  Width  address the instruction came from.
REQ-015 OpCode  output  eOperation  bits [15:12].
REQ-016 RegA / RegB  output  6 each  bits [11:6] / [5:0].
REQ-017 PcWrite  output  1  high when RegA equals SPECIAL_PC (63) and OpCode is not STORE or JR.

Function
REQ-018 SHALL implement the three-state FSM FETCH, HOLD, DRAIN.
REQ-019 FETCH: MemReq=1, MemAddr=PC; on MemAck, capture MemData and PC into the output registers, set PC to PC+1, set InstrValid=1, and go to HOLD.
REQ-020 HOLD: MemReq=0; outputs held stable; on InstrReady=1, clear InstrValid and go to FETCH (one instruction per 2+ cycles).
REQ-021 MemReq and MemAddr SHALL remain stable from assertion until the MemAck cycle inclusive; a request SHALL never be withdrawn.
REQ-022 Jump in HOLD: clear InstrValid immediately (the squashed instruction is never accepted, even if InstrReady=1 the same cycle), set PC to JumpTarget, and go to FETCH.
REQ-023 Jump in FETCH without MemAck: set PC to JumpTarget and go to DRAIN; MemAddr keeps the old address.
REQ-024 Jump in FETCH with MemAck the same cycle: discard MemData, set PC to JumpTarget, keep InstrValid=0, and go to FETCH.
REQ-025 DRAIN: MemReq=1 with the old address; on MemAck, discard the data and go to FETCH at PC; a further Jump in DRAIN overwrites PC (the last target wins).
REQ-026 Jump SHALL have priority over InstrReady and MemAck in every state.
REQ-027 PC increment SHALL wrap modulo 2^Width (16'hFFFF+1 -> 16'h0000).
REQ-028 Decoded fields SHALL be derived combinationally from the registered InstrWord (no extra latency).

Reset
REQ-029 On nReset=0: state=FETCH, PC=ResetVector, InstrValid=0, InstrWord=0, InstrPc=0; MemReq reads 0 during reset and becomes 1 on the first clock edge after release.
REQ-030 Reset mid-request SHALL abandon the transaction; any MemAck that arrives during reset is ignored.

Configuration
REQ-031 Macro FETCH_TRACE_EN, when defined, SHALL add output FetchCount (32 bits), reset to 0, which increments on each instruction accepted (InstrValid & InstrReady & ~Jump) and wraps.
REQ-032 Without FETCH_TRACE_EN, the FetchCount port and its counter SHALL be absent.

Structure
REQ-033 eFetchState (FETCH, HOLD, DRAIN) SHALL be added to InstructionSetPkg; field positions and widths SHALL come from the package constants OpCodeStart/Size, RegAStart/Size, RegBStart/Size, and SPECIAL_PC, never literals.
REQ-034 Field splitting and the PcWrite rule SHALL live in the combinational sub-module instruction_field_decode, instantiated once.

Verification
REQ-035 Reset release, MemAck one cycle after each request, InstrReady=1 -> MemAddr sequence 0,1,2; InstrPc matches each address.
REQ-036 MemData=16'hA1C5 -> OpCode=ADC, RegA=7, RegB=5, PcWrite=0; MemData=16'h3FC2 -> OpCode=MOVE, RegA=63, PcWrite=1.
REQ-037 InstrReady=0 for 5 cycles in HOLD -> InstrValid and InstrWord stable, MemReq=0 throughout.
REQ-038 Jump to 16'h0040 while a request to 16'h0003 is outstanding, MemAck 3 cycles later -> MemAddr stays 16'h0003 until ack, no InstrValid, next request at 16'h0040.
REQ-039 Jump in HOLD with InstrReady=1 the same cycle -> instruction not counted (FETCH_TRACE_EN), next MemAddr=JumpTarget; PC=16'hFFFF fetch -> next MemAddr=16'h0000.
REQ-040 nReset asserted while MemReq=1 -> outputs reach their reset values asynchronously; after release, fetch restarts at ResetVector.
